// File: rtl/drop_scheduler.sv
// Fall-step and spawn scheduler for a three-column falling-letter game.
// A level-dependent prescaler produces ticks; a round-robin picker spawns letters into free columns.
module drop_scheduler #(
    parameter int unsigned TICK_BASE = 25000000,
    parameter int unsigned TICK_STEP = 1500000,
    parameter int unsigned TICK_MIN  = 5000000,
    parameter int unsigned SPAWN_GAP = 8
) (
    input  logic       clock,
    input  logic       reset_signal,
    input  logic       enable,
    input  logic [7:0] score,
    input  logic [2:0] correct,
    input  logic [2:0] game_over,
    output logic [2:0] step,
    output logic [2:0] spawn,
    output logic [2:0] active,
    output logic [3:0] level,
    output logic       halted,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] BASE_P = 32'(TICK_BASE);
    localparam logic [31:0] STEP_P = 32'(TICK_STEP);
    localparam logic [31:0] MIN_P  = 32'(TICK_MIN);
    localparam logic [7:0]  GAP_P  = 8'(SPAWN_GAP);

    state_t      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] period_q, period_d;
    logic [7:0]  gap_q, gap_d;
    logic [1:0]  rr_q, rr_d;
    logic [2:0]  active_q, active_d;
    logic [3:0]  level_q, level_d;

    logic [31:0] dec;
    logic [31:0] period_calc;
    logic        run;
    logic        tick;
    logic        found;
    logic [1:0]  chosen;
    logic [1:0]  idx;
    logic [2:0]  idx_sum;
    logic        can_spawn;

    // Period for the current level, clamped so underflow cannot wrap to a huge value.
    always_comb begin
        dec = 32'(level_q) * STEP_P;
        if (dec >= BASE_P || (BASE_P - dec) < MIN_P) begin
            period_calc = MIN_P;
        end else begin
            period_calc = BASE_P - dec;
        end
    end

    // Round-robin search over inactive columns starting at rr.
    always_comb begin
        found   = 1'b0;
        chosen  = 2'd0;
        idx     = 2'd0;
        idx_sum = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx_sum = {1'b0, rr_q} + 3'(k);
            idx     = (idx_sum >= 3'd3) ? 2'(idx_sum - 3'd3) : idx_sum[1:0];
            if (!found && !active_q[idx]) begin
                found  = 1'b1;
                chosen = idx;
            end
        end
    end

    always_comb begin
        run       = (state_q == ST_RUN);
        tick      = run && (presc_q == period_q - 32'd1);
        can_spawn = run && (gap_q == GAP_P) && found;
        step      = tick ? active_q : 3'b000;
        spawn     = can_spawn ? (3'b001 << chosen) : 3'b000;
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        period_d = period_q;
        gap_d    = gap_q;
        rr_d     = rr_q;
        active_d = active_q;
        level_d  = score[7:4];

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (|game_over) begin
                    state_d = ST_HALT;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q == ST_RUN) begin
            presc_d = tick ? 32'd0 : presc_q + 32'd1;
        end else if (state_q == ST_HALT) begin
            presc_d = 32'd0;
        end

        // The next period is only picked up at a wrap so a running period is never cut short.
        if (tick) begin
            period_d = period_calc;
            if (gap_q != GAP_P) begin
                gap_d = gap_q + 8'd1;
            end
        end

        if (can_spawn) begin
            gap_d = 8'd0;
            rr_d  = (chosen == 2'd2) ? 2'd0 : chosen + 2'd1;
        end

        if (state_q != ST_HALT) begin
            active_d = (active_q & ~correct) | spawn;
        end
    end

    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state_q  <= ST_IDLE;
            presc_q  <= 32'd0;
            period_q <= BASE_P;
            gap_q    <= GAP_P;
            rr_q     <= 2'd0;
            active_q <= 3'b000;
            level_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            period_q <= period_d;
            gap_q    <= gap_d;
            rr_q     <= rr_d;
            active_q <= active_d;
            level_q  <= level_d;
        end
    end

    assign active    = active_q;
    assign level     = level_q;
    assign halted    = (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler with TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, SPAWN_GAP=2.
// Expected step/spawn timing and column choices are hand-derived from the scheduling rules.
module tb_drop_scheduler;

    logic       clock;
    logic       reset_signal;
    logic       enable;
    logic [7:0] score;
    logic [2:0] correct;
    logic [2:0] game_over;
    logic [2:0] step;
    logic [2:0] spawn;
    logic [2:0] active;
    logic [3:0] level;
    logic       halted;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc;

    drop_scheduler #(
        .TICK_BASE(10),
        .TICK_STEP(2),
        .TICK_MIN (4),
        .SPAWN_GAP(2)
    ) dut (
        .clock       (clock),
        .reset_signal(reset_signal),
        .enable      (enable),
        .score       (score),
        .correct     (correct),
        .game_over   (game_over),
        .step        (step),
        .spawn       (spawn),
        .active      (active),
        .level       (level),
        .halted      (halted),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clock);
        #1;
    endtask

    // Advances until step or spawn is nonzero; cyc is the cycle count, or -1 if the budget ran out.
    task automatic find_event(input int budget, output int cyc_o);
        bit done;
        done  = 1'b0;
        cyc_o = -1;
        for (int i = 1; i <= budget; i++) begin
            if (!done) begin
                tick_clk();
                if ((step | spawn) != 3'b000) begin
                    cyc_o = i;
                    done  = 1'b1;
                end
            end
        end
    endtask

    initial begin
        reset_signal = 1'b1;
        enable       = 1'b0;
        score        = 8'h00;
        correct      = 3'b000;
        game_over    = 3'b000;
        #2;
        check("rst_step", 32'(step), 32'h0);
        check("rst_spawn", 32'(spawn), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        tick_clk();
        reset_signal = 1'b0;
        enable = 1'b1;

        // First spawn on first RUN cycle, then ticks every 10 cycles
        find_event(3, cyc);
        check("first_spawn_cyc", 32'(cyc), 32'd1);
        check("first_spawn", 32'(spawn), 32'h1);
        check("first_spawn_state", 32'(dbg_state), 32'h1);
        find_event(15, cyc);
        check("tick1_cyc", 32'(cyc), 32'd9);
        check("tick1_step", 32'(step), 32'h1);
        find_event(15, cyc);
        check("tick2_cyc", 32'(cyc), 32'd10);
        find_event(15, cyc);
        check("spawn2_cyc", 32'(cyc), 32'd1);
        check("spawn2", 32'(spawn), 32'h2);
        find_event(15, cyc);
        check("tick3_step", 32'(step), 32'h3);
        find_event(15, cyc);
        check("tick4_cyc", 32'(cyc), 32'd10);
        find_event(15, cyc);
        check("spawn3", 32'(spawn), 32'h4);
        tick_clk();
        check("all_active", 32'(active), 32'h7);

        // correct clears a column, gap expiry respawns it
        correct = 3'b010;
        tick_clk();
        correct = 3'b000;
        check("corr_clear", 32'(active), 32'h5);
        find_event(15, cyc);
        check("tick5_cyc", 32'(cyc), 32'd7);
        check("tick5_step", 32'(step), 32'h5);
        find_event(15, cyc);
        check("tick6_cyc", 32'(cyc), 32'd10);
        find_event(15, cyc);
        check("respawn_cyc", 32'(cyc), 32'd1);
        check("respawn", 32'(spawn), 32'h2);
        tick_clk();
        check("respawn_active", 32'(active), 32'h7);

        // Two free columns: rr=2 must pick column 2 over column 0
        correct = 3'b101;
        tick_clk();
        correct = 3'b000;
        check("corr_two", 32'(active), 32'h2);
        find_event(15, cyc);
        check("tick7_step", 32'(step), 32'h2);
        find_event(15, cyc);
        check("tick8_cyc", 32'(cyc), 32'd10);
        find_event(15, cyc);
        check("rr_pick2", 32'(spawn), 32'h4);
        tick_clk();
        check("rr_active", 32'(active), 32'h6);

        // correct on an inactive column is ignored
        correct = 3'b001;
        tick_clk();
        correct = 3'b000;
        check("corr_ignore", 32'(active), 32'h6);

        // correct coinciding with a tick: step still pulses
        find_event(15, cyc);
        check("tick9_cyc", 32'(cyc), 32'd7);
        check("tick9_step", 32'(step), 32'h6);
        correct = 3'b010;
        tick_clk();
        correct = 3'b000;
        check("corr_on_tick", 32'(active), 32'h4);
        find_event(15, cyc);
        check("tick10_cyc", 32'(cyc), 32'd9);
        check("tick10_step", 32'(step), 32'h4);
        find_event(15, cyc);
        check("rr_pick0", 32'(spawn), 32'h1);
        tick_clk();
        tick_clk();

        // Pause 3 cycles into the period; prescaler holds in IDLE
        enable = 1'b0;
        find_event(20, cyc);
        check("idle_quiet", 32'(cyc), 32'hFFFF_FFFF);
        check("idle_state", 32'(dbg_state), 32'h0);
        correct = 3'b100;
        tick_clk();
        correct = 3'b000;
        check("idle_corr", 32'(active), 32'h1);
        enable = 1'b1;
        find_event(15, cyc);
        check("resume_cyc", 32'(cyc), 32'd7);
        check("resume_step", 32'(step), 32'h1);

        // Level change mid-period does not truncate the running period
        tick_clk();
        tick_clk();
        score = 8'h30;
        check("level_pre", 32'(level), 32'h0);
        tick_clk();
        check("level_3", 32'(level), 32'h3);
        find_event(15, cyc);
        check("lvl_tick_cyc", 32'(cyc), 32'd7);
        find_event(15, cyc);
        check("lvl_spawn", 32'(spawn), 32'h2);
        find_event(15, cyc);
        check("p4_first_cyc", 32'(cyc), 32'd3);
        check("p4_first_step", 32'(step), 32'h3);
        find_event(15, cyc);
        check("p4_cyc", 32'(cyc), 32'd4);
        score = 8'hF0;
        find_event(15, cyc);
        check("lvl_spawn2", 32'(spawn), 32'h4);
        check("level_15", 32'(level), 32'hF);
        find_event(15, cyc);
        check("clamp_a_cyc", 32'(cyc), 32'd3);
        check("clamp_a_step", 32'(step), 32'h7);
        find_event(15, cyc);
        check("clamp_b_cyc", 32'(cyc), 32'd4);

        // game_over beats enable=0; HALT freezes everything
        game_over = 3'b100;
        enable = 1'b0;
        tick_clk();
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_state", 32'(dbg_state), 32'h2);
        check("halt_active", 32'(active), 32'h7);
        game_over = 3'b000;
        correct = 3'b111;
        enable = 1'b1;
        find_event(6, cyc);
        check("halt_quiet_a", 32'(cyc), 32'hFFFF_FFFF);
        enable = 1'b0;
        correct = 3'b000;
        find_event(6, cyc);
        check("halt_quiet_b", 32'(cyc), 32'hFFFF_FFFF);
        enable = 1'b1;
        tick_clk();
        check("halt_stuck", 32'(halted), 32'h1);
        check("halt_frozen", 32'(active), 32'h7);

        // Asynchronous reset between edges
        #2;
        reset_signal = 1'b1;
        #1;
        check("async_halted", 32'(halted), 32'h0);
        check("async_active", 32'(active), 32'h0);
        check("async_level", 32'(level), 32'h0);
        check("async_state", 32'(dbg_state), 32'h0);
        reset_signal = 1'b0;
        enable = 1'b0;
        tick_clk();
        check("post_rst_state", 32'(dbg_state), 32'h0);
        check("post_rst_level", 32'(level), 32'hF);
        enable = 1'b1;
        find_event(3, cyc);
        check("post_rst_spawn_cyc", 32'(cyc), 32'd1);
        check("post_rst_spawn", 32'(spawn), 32'h1);
        find_event(15, cyc);
        check("post_rst_period", 32'(cyc), 32'd9);
        check("post_rst_step", 32'(step), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
